// File: rtl/cam_pkg.sv
// Shared camera front-end definitions: frame geometry, pixel type, capture FSM states and
// the colour-region boundaries that the classifier also depends on.
package cam_pkg;

    localparam int unsigned IMG_W_DEF = 320;
    localparam int unsigned IMG_H_DEF = 240;
    localparam int unsigned COL_W     = 9;
    localparam int unsigned ROW_W     = 8;

    // Test-pattern / classifier region boundaries (first column of each region).
    localparam logic [COL_W-1:0] REGION_ORANGE_START = 9'd100;
    localparam logic [COL_W-1:0] REGION_GREY_START   = 9'd295;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        LINE_IDLE,
        BYTE_HI,
        BYTE_LO
    } capture_state_t;

endpackage

// File: rtl/orange_threshold.sv
// Combinational orange colour test on one RGB444 pixel; all compares are unsigned nibbles.
module orange_threshold
    import cam_pkg::*;
#(
    parameter logic [3:0] R_MIN = 4'd10,
    parameter logic [3:0] G_MIN = 4'd3,
    parameter logic [3:0] G_MAX = 4'd8,
    parameter logic [3:0] B_MAX = 4'd4
) (
    input  rgb444_t px_i,
    output logic    is_orange_o
);

    assign is_orange_o = (px_i.r >= R_MIN) && (px_i.g >= G_MIN) && (px_i.g <= G_MAX) &&
                         (px_i.b <= B_MAX) && (px_i.r > px_i.g);

endmodule

// File: rtl/ov_pixel_capture.sv
// OV7670 RGB444 byte-pair capture with row/column tracking and orange thresholding.
// Define CAPTURE_TEST_PATTERN_EN to replace camera colours with a column-based test pattern.
module ov_pixel_capture
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter logic [3:0]  R_MIN = 4'd10,
    parameter logic [3:0]  G_MIN = 4'd3,
    parameter logic [3:0]  G_MAX = 4'd8,
    parameter logic [3:0]  B_MAX = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] d,
    output logic       pix_valid,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [8:0] col,
    output logic [7:0] row,
    output logic       is_orange,
    output logic       line_active,
    output logic       frame_done,
    output logic       byte_err
);

    localparam logic [COL_W-1:0] ColLimit = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0] RowLimit = ROW_W'(IMG_H);

    logic             vsync_q;
    logic             vsync_p_q;
    logic             href_q;
    logic [7:0]       d_q;
    capture_state_t   state_q;
    logic [3:0]       red_lat_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             pix_valid_q;
    logic [3:0]       red_q;
    logic [3:0]       green_q;
    logic [3:0]       blue_q;
    logic [COL_W-1:0] col_out_q;
    logic [ROW_W-1:0] row_out_q;
    logic             orange_q;
    logic             line_active_q;
    logic             frame_done_q;
    logic             byte_err_q;

    rgb444_t px_d;
    logic    px_orange;
    logic    vsync_fall;
    logic    px_keep;

    always_comb begin
`ifdef CAPTURE_TEST_PATTERN_EN
        if (col_q < REGION_ORANGE_START) begin
            px_d = '{r: 4'h0, g: 4'h0, b: 4'hF};
        end else if (col_q < REGION_GREY_START) begin
            px_d = '{r: 4'hF, g: 4'h6, b: 4'h0};
        end else begin
            px_d = '{r: 4'h8, g: 4'h8, b: 4'h8};
        end
`else
        px_d = '{r: red_lat_q, g: d_q[7:4], b: d_q[3:0]};
`endif
    end

    assign vsync_fall = vsync_p_q & ~vsync_q;
    // Pixels past the last column or after the last row are consumed but never emitted.
    assign px_keep    = (col_q < ColLimit) && (row_q < RowLimit);

    orange_threshold #(
        .R_MIN(R_MIN),
        .G_MIN(G_MIN),
        .G_MAX(G_MAX),
        .B_MAX(B_MAX)
    ) u_thresh (
        .px_i       (px_d),
        .is_orange_o(px_orange)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            vsync_p_q     <= 1'b0;
            href_q        <= 1'b0;
            d_q           <= '0;
            state_q       <= WAIT_FRAME;
            red_lat_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pix_valid_q   <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            col_out_q     <= '0;
            row_out_q     <= '0;
            orange_q      <= 1'b0;
            line_active_q <= 1'b0;
            frame_done_q  <= 1'b0;
            byte_err_q    <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            vsync_p_q    <= vsync_q;
            href_q       <= href;
            d_q          <= d;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            // vsync outranks any href activity, including a byte arriving in the same cycle.
            if (state_q != WAIT_FRAME && vsync_q) begin
                state_q       <= WAIT_FRAME;
                frame_done_q  <= 1'b1;
                line_active_q <= 1'b0;
            end else begin
                unique case (state_q)
                    WAIT_FRAME: begin
                        if (vsync_fall) begin
                            state_q    <= LINE_IDLE;
                            row_q      <= '0;
                            col_q      <= '0;
                            byte_err_q <= 1'b0;
                        end
                    end
                    LINE_IDLE: begin
                        if (href_q) begin
                            red_lat_q <= d_q[3:0];
                            state_q   <= BYTE_LO;
                        end
                    end
                    BYTE_HI: begin
                        if (href_q) begin
                            red_lat_q <= d_q[3:0];
                            state_q   <= BYTE_LO;
                        end else begin
                            state_q       <= LINE_IDLE;
                            col_q         <= '0;
                            col_out_q     <= '0;
                            line_active_q <= 1'b0;
                            if (line_active_q) row_q <= row_q + 1'b1;
                        end
                    end
                    BYTE_LO: begin
                        if (href_q) begin
                            state_q <= BYTE_HI;
                            if (px_keep) begin
                                pix_valid_q   <= 1'b1;
                                red_q         <= px_d.r;
                                green_q       <= px_d.g;
                                blue_q        <= px_d.b;
                                col_out_q     <= col_q;
                                row_out_q     <= row_q;
                                orange_q      <= px_orange;
                                line_active_q <= 1'b1;
                                col_q         <= col_q + 1'b1;
                            end
                        end else begin
                            // Line ended mid-pixel: the latched high byte is dropped.
                            state_q       <= LINE_IDLE;
                            byte_err_q    <= 1'b1;
                            col_q         <= '0;
                            col_out_q     <= '0;
                            line_active_q <= 1'b0;
                            if (line_active_q) row_q <= row_q + 1'b1;
                        end
                    end
                    default: state_q <= WAIT_FRAME;
                endcase
            end
        end
    end

    assign pix_valid   = pix_valid_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign col         = col_out_q;
    assign row         = row_out_q;
    assign is_orange   = orange_q;
    assign line_active = line_active_q;
    assign frame_done  = frame_done_q;
    assign byte_err    = byte_err_q;

endmodule

// File: tb/tb_ov_pixel_capture.sv
// Directed bench for ov_pixel_capture: a byte-level frame model feeds a pixel scoreboard,
// plus literal checks on latency, line timing, error flags and frame strobes.
module tb_ov_pixel_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] d = 8'h00;
    logic       pix_valid;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic [8:0] col;
    logic [7:0] row;
    logic       is_orange;
    logic       line_active;
    logic       frame_done;
    logic       byte_err;

    always #5 clk = ~clk;

    ov_pixel_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .pix_valid  (pix_valid),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .col        (col),
        .row        (row),
        .is_orange  (is_orange),
        .line_active(line_active),
        .frame_done (frame_done),
        .byte_err   (byte_err)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic [8:0]  c;
        logic [7:0]  rw;
        logic        o;
    } px_t;

    px_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int npix = 0;
    int fpix = 0;
    int la_cnt = 0;
    int fd_cnt = 0;
    int t_lo = 0;
    int first_pix_cyc = -1;
    logic [8:0]  last_col = '0;
    logic [7:0]  last_row = '0;
    logic [11:0] last_rgb = '0;
    logic        last_or = 1'b0;
    logic        or_hist [0:1];
    logic [11:0] col_rgb [0:319];

    // Frame model state, advanced once per driven pin cycle.
    logic       m_vprev = 1'b0;
    logic       m_armed = 1'b0;
    logic       m_par = 1'b0;
    logic       m_inline = 1'b0;
    logic       m_emit = 1'b0;
    logic [7:0] m_hi = '0;
    int         m_col = 0;
    int         m_row = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int c, input logic [7:0] hi,
                                              input logic [7:0] lo);
`ifdef CAPTURE_TEST_PATTERN_EN
        if (c < 100) return 12'h00F;
        if (c < 295) return 12'hF60;
        return 12'h888;
`else
        return {hi[3:0], lo};
`endif
    endfunction

    function automatic logic model_orange(input logic [11:0] rgb);
        int r, g, b;
        r = int'(rgb[11:8]);
        g = int'(rgb[7:4]);
        b = int'(rgb[3:0]);
        return (r >= 10) && (g >= 3) && (g <= 8) && (b <= 4) && (r > g);
    endfunction

    task automatic model_step(input logic v, input logic h, input logic [7:0] b);
        px_t e;
        if (v) begin
            m_armed = 1'b0;
        end else if (m_vprev) begin
            m_armed = 1'b1;
            m_row = 0;
            m_col = 0;
            m_par = 1'b0;
            m_inline = 1'b0;
            m_emit = 1'b0;
        end else if (m_armed) begin
            if (h) begin
                m_inline = 1'b1;
                if (!m_par) begin
                    m_hi = b;
                    m_par = 1'b1;
                end else begin
                    m_par = 1'b0;
                    if (m_col < 320 && m_row < 240) begin
                        e.rgb = model_rgb(m_col, m_hi, b);
                        e.c = 9'(m_col);
                        e.rw = 8'(m_row);
                        e.o = model_orange(e.rgb);
                        exp_q.push_back(e);
                        m_col++;
                        m_emit = 1'b1;
                    end
                end
            end else if (m_inline) begin
                if (m_emit) m_row++;
                m_col = 0;
                m_par = 1'b0;
                m_inline = 1'b0;
                m_emit = 1'b0;
            end
        end
        m_vprev = v;
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] b);
        model_step(v, h, b);
        vsync = v;
        href = h;
        d = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic new_frame();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
        idle(3);
    endtask

    task automatic pix(input logic [7:0] hi, input logic [7:0] lo);
        drive(1'b0, 1'b1, hi);
        drive(1'b0, 1'b1, lo);
    endtask

    task automatic line(input int n, input logic [7:0] hi0, input logic [7:0] lo0,
                        input logic [7:0] step);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) b = hi0 + 8'(k / 2) * step;
            else b = lo0 + 8'(k / 2) * step * 8'd3;
            if (k == 1) t_lo = cyc;
            drive(1'b0, 1'b1, b);
        end
        idle(4);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (line_active) la_cnt++;
            if (frame_done) fd_cnt++;
            if (pix_valid) begin
                px_t e;
                if (npix < 2) or_hist[npix] = is_orange;
                npix++;
                fpix++;
                if (first_pix_cyc < 0) first_pix_cyc = cyc;
                if (col < 9'd320) col_rgb[col] = {red, green, blue};
                last_col = col;
                last_row = row;
                last_rgb = {red, green, blue};
                last_or = is_orange;
                chk("line_active_during_pix", 64'(line_active), 64'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pix: got pixel col=%0d row=%0d, required none",
                             col, row);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", 64'({red, green, blue, col, row, is_orange}), 64'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({pix_valid, line_active, frame_done, byte_err, red, green,
            blue, col, row, is_orange}), 64'd0);
        rst_n = 1'b1;
        idle(3);
        chk("idle_after_reset", 64'({pix_valid, line_active, frame_done, byte_err}), 64'd0);

        // Frame 1: full line, then an over-long line
        new_frame();
        chk("no_frame_done_from_wait", 64'(fd_cnt), 64'd0);
        npix = 0;
        la_cnt = 0;
        first_pix_cyc = -1;
        line(640, 8'h0F, 8'h50, 8'h00);
        chk("line640_pix_count", 64'(npix), 64'd320);
        chk("line640_line_active_span", 64'(la_cnt), 64'd639);
        chk("pix_latency", 64'(first_pix_cyc - t_lo), 64'd2);
        chk("line640_last_col", 64'(last_col), 64'd319);
        chk("line640_row", 64'(last_row), 64'd0);
        chk("line_active_after_line", 64'(line_active), 64'd0);
`ifdef CAPTURE_TEST_PATTERN_EN
        chk("pattern_col99_blue", 64'(col_rgb[99]), 64'h00F);
        chk("pattern_col100_orange", 64'(col_rgb[100]), 64'hF60);
        chk("pattern_col295_grey", 64'(col_rgb[295]), 64'h888);
`else
        chk("line640_rgb", 64'(last_rgb), 64'hF50);
        chk("line640_orange", 64'(last_or), 64'd1);
        chk("line640_col100_rgb", 64'(col_rgb[100]), 64'hF50);
`endif
        npix = 0;
        line(642, 8'h0F, 8'h50, 8'h00);
        chk("line642_pix_count", 64'(npix), 64'd320);
        chk("line642_byte_err", 64'(byte_err), 64'd0);
        chk("line642_col_reset", 64'(col), 64'd0);
        chk("line642_row", 64'(last_row), 64'd1);
        chk("frame1_all_pix_seen", 64'(exp_q.size()), 64'd0);

        // Frame 2: short odd line, then following lines
        new_frame();
        chk("frame_done_count_f2", 64'(fd_cnt), 64'd1);
        npix = 0;
        line(5, 8'h0F, 8'h50, 8'h00);
        chk("odd_line_pix_count", 64'(npix), 64'd2);
        chk("odd_line_byte_err", 64'(byte_err), 64'd1);
        line(4, 8'h0C, 8'h46, 8'h00);
        chk("row_after_odd_line", 64'(last_row), 64'd1);
        chk("byte_err_sticky", 64'(byte_err), 64'd1);
        line(40, 8'h03, 8'h12, 8'h11);
        line(60, 8'hAB, 8'h27, 8'h05);

        // Frame 3: R_MIN boundary, then vsync abort mid-line
        new_frame();
        chk("frame_done_count_f3", 64'(fd_cnt), 64'd2);
        chk("byte_err_cleared", 64'(byte_err), 64'd0);
        npix = 0;
        pix(8'h0A, 8'h34);
        pix(8'h09, 8'h34);
        idle(4);
        chk("boundary_pix_count", 64'(npix), 64'd2);
`ifndef CAPTURE_TEST_PATTERN_EN
        chk("rmin_boundary_orange", 64'(or_hist[0]), 64'd1);
        chk("below_rmin_not_orange", 64'(or_hist[1]), 64'd0);
`endif
        npix = 0;
        for (int i = 0; i < 10; i++) pix(8'h0F, 8'h50);
        begin
            int fd0;
            fd0 = fd_cnt;
            drive(1'b1, 1'b1, 8'h0F);
            drive(1'b1, 1'b1, 8'h50);
            chk("abort_line_active", 64'(line_active), 64'd0);
            for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'h0F);
            for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
            chk("abort_pix_count", 64'(npix), 64'd10);
            chk("abort_frame_done_once", 64'(fd_cnt - fd0), 64'd1);
        end

        // Reset asserted mid-line
        new_frame();
        npix = 0;
        pix(8'h0F, 8'h50);
        pix(8'h0F, 8'h50);
        drive(1'b0, 1'b1, 8'h0F);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midline_reset_outputs", 64'({pix_valid, line_active, frame_done, byte_err, red,
            green, blue, col, row, is_orange}), 64'd0);
        chk("midline_reset_pix_seen", 64'(npix), 64'd2);
        chk("midline_reset_pending", 64'(exp_q.size()), 64'd0);
        m_armed = 1'b0;
        m_vprev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        npix = 0;
        for (int i = 0; i < 4; i++) pix(8'h0F, 8'h50);
        idle(4);
        chk("no_capture_before_vsync", 64'(npix), 64'd0);
        new_frame();
        line(4, 8'h0F, 8'h50, 8'h00);
        chk("resume_pix_count", 64'(npix), 64'd2);
        chk("resume_row", 64'(last_row), 64'd0);

        // Frame 4: one more line than the frame holds
        new_frame();
        fpix = 0;
        for (int l = 0; l < 241; l++) line(8, 8'(l), 8'h35, 8'h05);
        chk("frame_pix_count", 64'(fpix), 64'd960);
        chk("frame_last_row", 64'(last_row), 64'd239);
        chk("frame4_all_pix_seen", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
